// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART program loader
// Purpose: RX and loader state encodings, default baud divisor, frame header length.
// Ports: none (package).
package loader_pkg;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // count high byte + count low byte
  localparam int HDR_LEN = 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_CNT_HI,
    L_CNT_LO,
    L_DATA_HI,
    L_DATA_LO,
    L_CHK,
    L_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer
// Purpose: synchronizes rx, detects the start edge, samples mid-bit and
//          reports each character with a good or bad stop bit.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   rx               : raw serial input, idle high
//   byte_out[7:0]    : last received character (valid with byte_valid)
//   byte_valid       : one-cycle pulse, stop bit sampled high
//   byte_err         : one-cycle pulse, stop bit sampled low
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  logic w_fall;
  logic w_stop_sample;

  assign w_fall        = r_prev & ~r_sync2;
  assign w_stop_sample = (r_state == RX_STOP) && (r_cnt == C_FULL);

  // Reported combinationally so the loader sees the character in the stop-sample cycle.
  assign byte_out   = r_shift;
  assign byte_valid = w_stop_sample & r_sync2;
  assign byte_err   = w_stop_sample & ~r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            r_bit <= 3'd0;
            // Line back high at mid-start means a glitch, not a character.
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Back to idle in the sample cycle so a back-to-back start edge is caught next cycle.
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - loads a framed program image from UART into instruction RAM
// Purpose: parses count / data words / XOR checksum, writes words through RAM
//          port B and holds the CPU PC until a good image has been loaded.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   rx                   : UART serial input
//   mem_we               : one-cycle RAM write strobe
//   mem_addr[ADDR_W-1:0] : RAM write address (holds until next write)
//   mem_data[15:0]       : RAM write data (holds until next write)
//   cpu_hold             : 1 freezes the CPU program counter
//   done                 : one-cycle pulse on a load with good checksum
//   frame_err, chk_err   : sticky error flags, cleared only by reset
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              frame_err,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (w_byte),
    .byte_valid(w_byte_valid),
    .byte_err  (w_byte_err)
  );

  ld_state_t         r_state;
  logic [15:0]       r_count;   // words still to receive
  logic [ADDR_W-1:0] r_addr;    // next write address
  logic [7:0]        r_chk;     // running XOR of frame bytes
  logic [7:0]        r_hi;      // high byte of the word in flight
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_frame_err;
  logic              r_chk_err;

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign chk_err   = r_chk_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= L_CNT_HI;
      r_count     <= 16'h0000;
      r_addr      <= '0;
      r_chk       <= 8'h00;
      r_hi        <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= 16'h0000;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_chk_err   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      if (w_byte_err) begin
        // Abort the frame; words already written stay in RAM.
        r_frame_err <= 1'b1;
        r_state     <= L_CNT_HI;
        r_addr      <= '0;
        r_chk       <= 8'h00;
        r_cpu_hold  <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_state)
          // A byte arriving after a completed load starts a new frame.
          L_CNT_HI, L_DONE: begin
            r_count[15:8] <= w_byte;
            r_chk         <= w_byte;
            r_addr        <= '0;
            r_cpu_hold    <= 1'b1;
            r_state       <= L_CNT_LO;
          end
          L_CNT_LO: begin
            r_count[7:0] <= w_byte;
            r_chk        <= r_chk ^ w_byte;
            r_state      <= ({r_count[15:8], w_byte} == 16'h0000) ? L_CHK : L_DATA_HI;
          end
          L_DATA_HI: begin
            r_hi    <= w_byte;
            r_chk   <= r_chk ^ w_byte;
            r_state <= L_DATA_LO;
          end
          L_DATA_LO: begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_data <= {r_hi, w_byte};
            r_addr     <= r_addr + ADDR_ONE;
            r_chk      <= r_chk ^ w_byte;
            r_count    <= r_count - 16'd1;
            r_state    <= (r_count == 16'd1) ? L_CHK : L_DATA_HI;
          end
          L_CHK: begin
            if (w_byte == r_chk) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_state    <= L_DONE;
            end else begin
              r_chk_err  <= 1'b1;
              r_cpu_hold <= 1'b1;
              r_state    <= L_CNT_HI;
            end
          end
          default: r_state <= L_CNT_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int CPB = 8;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        frame_err;
  logic        chk_err;

  int checks;
  int failures;

  // Write / done monitor; sole writer of these variables.
  int          wr_cnt;
  int          done_cnt;
  logic [15:0] wr_addr_log [64];
  logic [15:0] wr_data_log [64];

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .frame_err(frame_err),
    .chk_err  (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_cnt   = 0;
    done_cnt = 0;
  end

  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = mem_addr;
        wr_data_log[wr_cnt] = mem_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (reset && done) done_cnt = done_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_val;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic send_normal_frame();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_cycles(4);
  endtask

  task automatic test_reset();
    rx    = 1'b1;
    reset = 1'b0;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (chk_err !== 1'b0) begin failures++; $display("FAIL reset_chk_err got=%b exp=0", chk_err); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_data !== 16'h0000) begin failures++; $display("FAIL reset_mem_data got=%h exp=0000", mem_data); end
  endtask

  task automatic test_normal_load();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    send_normal_frame();
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL normal_write_count got=%0d exp=2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb] !== 16'h0000 || wr_data_log[wb] !== 16'h1234) begin
      failures++; $display("FAIL normal_word0 got=%h:%h exp=0000:1234", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (wr_addr_log[wb+1] !== 16'h0001 || wr_data_log[wb+1] !== 16'hABCD) begin
      failures++; $display("FAIL normal_word1 got=%h:%h exp=0001:abcd", wr_addr_log[wb+1], wr_data_log[wb+1]); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL normal_done_pulses got=%0d exp=1", done_cnt - db); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL normal_cpu_hold got=%b exp=0", cpu_hold); end
    checks++; if (mem_addr !== 16'h0001 || mem_data !== 16'hABCD) begin
      failures++; $display("FAIL normal_hold_outputs got=%h:%h exp=0001:abcd", mem_addr, mem_data); end
    checks++; if (chk_err !== 1'b0) begin failures++; $display("FAIL normal_chk_err got=%b exp=0", chk_err); end
  endtask

  task automatic test_empty_image();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    send_byte(8'h00, 1'b1);
    wait_cycles(2);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL empty_hold_on_new_frame got=%b exp=1", cpu_hold); end
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cycles(4);
    checks++; if (wr_cnt - wb !== 0) begin failures++; $display("FAIL empty_no_write got=%0d exp=0", wr_cnt - wb); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL empty_done_pulses got=%0d exp=1", done_cnt - db); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL empty_cpu_hold got=%b exp=0", cpu_hold); end
  endtask

  task automatic test_frame_error();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    wait_cycles(3 * CPB);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    checks++; if (wr_cnt - wb !== 0) begin failures++; $display("FAIL ferr_no_write got=%0d exp=0", wr_cnt - wb); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL ferr_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (done_cnt - db !== 0) begin failures++; $display("FAIL ferr_no_done got=%0d exp=0", done_cnt - db); end
    wb = wr_cnt; db = done_cnt;
    send_normal_frame();
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL ferr_reload_writes got=%0d exp=2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb] !== 16'h0000 || wr_data_log[wb] !== 16'h1234) begin
      failures++; $display("FAIL ferr_reload_word0 got=%h:%h exp=0000:1234", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL ferr_reload_done got=%0d exp=1", done_cnt - db); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL ferr_reload_cpu_hold got=%b exp=0", cpu_hold); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
  endtask

  task automatic test_bad_checksum();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    // Correct checksum would be 00^01^BE^EF = 50.
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h43, 1'b1);
    wait_cycles(4);
    checks++; if (wr_cnt - wb !== 1) begin failures++; $display("FAIL badchk_writes got=%0d exp=1", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb] !== 16'h0000 || wr_data_log[wb] !== 16'hBEEF) begin
      failures++; $display("FAIL badchk_word0 got=%h:%h exp=0000:beef", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (chk_err !== 1'b1) begin failures++; $display("FAIL badchk_flag got=%b exp=1", chk_err); end
    checks++; if (done_cnt - db !== 0) begin failures++; $display("FAIL badchk_no_done got=%0d exp=0", done_cnt - db); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL badchk_cpu_hold got=%b exp=1", cpu_hold); end
  endtask

  task automatic test_reset_and_glitch();
    int wb, db;
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b1 || frame_err !== 1'b0 || chk_err !== 1'b0 || mem_addr !== 16'h0000) begin
      failures++; $display("FAIL async_reset hold=%b ferr=%b cerr=%b addr=%h exp=1,0,0,0000", cpu_hold, frame_err, chk_err, mem_addr); end
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(3);
    wb = wr_cnt; db = done_cnt;
    send_normal_frame();
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL rst_reload_writes got=%0d exp=2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb] !== 16'h0000 || wr_data_log[wb] !== 16'h1234) begin
      failures++; $display("FAIL rst_reload_word0 got=%h:%h exp=0000:1234", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL rst_reload_done got=%0d exp=1", done_cnt - db); end
    wb = wr_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    wait_cycles(12 * CPB);
    // Any accepted byte would start a new frame and raise cpu_hold.
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL glitch_cpu_hold got=%b exp=0", cpu_hold); end
    checks++; if (wr_cnt - wb !== 0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL glitch_no_byte writes=%0d ferr=%b exp=0,0", wr_cnt - wb, frame_err); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normal_load();
    test_empty_image();
    test_frame_error();
    test_bad_checksum();
    test_reset_and_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
